// File: rtl/router_ctrl_if.sv
// Signal bundle between the packet source / output FIFOs and the router input controller.
// Handshake: a byte on data_in is transferred on a rising clock edge when pkt_valid=1 and
// busy=0; while busy=1 the source must hold pkt_valid and data_in unchanged.
interface router_ctrl_if;
  logic       pkt_valid;
  logic [7:0] data_in;
  logic [2:0] fifo_full;
  logic [2:0] fifo_empty;
  logic [2:0] read_enb;
  logic [7:0] data_out;
  logic [2:0] write_enb;
  logic       lfd_state;
  logic       busy;
  logic [2:0] vld_out;
  logic [2:0] soft_reset;
  logic       err;
  logic [2:0] state_dbg;

  modport master (
    output pkt_valid, data_in, fifo_full, fifo_empty, read_enb,
    input  data_out, write_enb, lfd_state, busy, vld_out, soft_reset, err, state_dbg
  );

  modport slave (
    input  pkt_valid, data_in, fifo_full, fifo_empty, read_enb,
    output data_out, write_enb, lfd_state, busy, vld_out, soft_reset, err, state_dbg
  );
endinterface

// File: rtl/router_ctrl.sv
// Input controller of the 1x3 packet router: header decode, FIFO write sequencing,
// backpressure, parity check and per-port drain timeout with soft reset.
module router_ctrl #(
  parameter int TIMEOUT = 30,
  parameter int TCNT_W  = 5
) (
  input  logic         clock,
  input  logic         resetn,
  router_ctrl_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WAIT_EMPTY = 3'd1,
    S_HDR        = 3'd2,
    S_DATA       = 3'd3,
    S_PARITY     = 3'd4,
    S_DROP       = 3'd5
  } state_t;

  state_t            state, state_nxt;
  logic [7:0]        hdr_q;
  logic [7:0]        parity_q;
  logic [5:0]        rem_q;
  logic              err_q;
  logic [2:0]        soft_reset_q;
  logic [TCNT_W-1:0] tcnt_q [3];

  logic [1:0] dest;
  logic [1:0] in_dest;
  logic [3:0] full_x;
  logic [3:0] empty_x;
  logic [3:0] sr_x;
  logic [2:0] dest_oh;
  logic       abort;
  logic       write;
  logic       busy_c;
  logic       lfd_c;
  logic [7:0] dout_c;

  // Padded to 4 bits so dest=3 (invalid) indexes a constant 0 instead of going out of range.
  assign dest    = hdr_q[1:0];
  assign in_dest = bus.data_in[1:0];
  assign full_x  = {1'b0, bus.fifo_full};
  assign empty_x = {1'b0, bus.fifo_empty};
  assign sr_x    = {1'b0, soft_reset_q};
  assign dest_oh = 3'b001 << dest;
  assign abort   = sr_x[dest];

  always_comb begin
    state_nxt = state;
    busy_c    = 1'b0;
    lfd_c     = 1'b0;
    write     = 1'b0;
    dout_c    = 8'h00;
    case (state)
      S_IDLE: begin
        if (bus.pkt_valid) begin
          if (in_dest == 2'd3) begin
            state_nxt = S_DROP;
          end else if (empty_x[in_dest]) begin
            lfd_c     = 1'b1;
            state_nxt = S_HDR;
          end else begin
            state_nxt = S_WAIT_EMPTY;
          end
        end
      end
      S_WAIT_EMPTY: begin
        busy_c = 1'b1;
        if (abort) begin
          state_nxt = S_DROP;
        end else if (empty_x[dest]) begin
          lfd_c     = 1'b1;
          state_nxt = S_HDR;
        end
      end
      S_HDR: begin
        busy_c = 1'b1;
        if (abort) begin
          state_nxt = S_DROP;
        end else if (!full_x[dest]) begin
          write     = 1'b1;
          dout_c    = hdr_q;
          state_nxt = (hdr_q[7:2] != 6'd0) ? S_DATA : S_PARITY;
        end
      end
      S_DATA: begin
        busy_c = full_x[dest];
        if (abort) begin
          state_nxt = S_DROP;
        end else if (bus.pkt_valid && !full_x[dest]) begin
          write  = 1'b1;
          dout_c = bus.data_in;
          if (rem_q == 6'd1) state_nxt = S_PARITY;
        end
      end
      S_PARITY: begin
        busy_c = full_x[dest];
        if (abort) begin
          state_nxt = S_DROP;
        end else if (bus.pkt_valid && !full_x[dest]) begin
          write     = 1'b1;
          dout_c    = bus.data_in;
          state_nxt = S_IDLE;
        end
      end
      S_DROP: begin
        if (!bus.pkt_valid) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state    <= S_IDLE;
      hdr_q    <= 8'h00;
      parity_q <= 8'h00;
      rem_q    <= 6'd0;
      err_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && bus.pkt_valid) begin
        hdr_q    <= bus.data_in;
        rem_q    <= bus.data_in[7:2];
        parity_q <= 8'h00;
      end
      if (write) begin
        case (state)
          S_HDR:    parity_q <= hdr_q;
          S_DATA: begin
            parity_q <= parity_q ^ bus.data_in;
            rem_q    <= rem_q - 6'd1;
          end
          S_PARITY: err_q <= (bus.data_in != parity_q);
          default: ;
        endcase
      end
    end
  end

  // A port "idles" when it holds data but its destination is not reading it.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      soft_reset_q <= 3'b000;
      for (int i = 0; i < 3; i++) tcnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (!bus.fifo_empty[i] && !bus.read_enb[i]) begin
          if (tcnt_q[i] == TCNT_W'(TIMEOUT - 1)) begin
            tcnt_q[i]       <= '0;
            soft_reset_q[i] <= 1'b1;
          end else begin
            tcnt_q[i]       <= tcnt_q[i] + TCNT_W'(1);
            soft_reset_q[i] <= 1'b0;
          end
        end else begin
          tcnt_q[i]       <= '0;
          soft_reset_q[i] <= 1'b0;
        end
      end
    end
  end

  assign bus.write_enb  = write ? dest_oh : 3'b000;
  assign bus.data_out   = dout_c;
  assign bus.lfd_state  = lfd_c;
  assign bus.busy       = busy_c;
  assign bus.vld_out    = ~bus.fifo_empty;
  assign bus.soft_reset = soft_reset_q;
  assign bus.err        = err_q;
  assign bus.state_dbg  = state;
endmodule
